// File: rtl/eyeriss_pkg.sv
// eyeriss_pkg: shared widths, GIN packet type and pointer-width helper
package eyeriss_pkg;
  localparam int DATA_BW_DEFAULT = 8;
  localparam int ID_BW_DEFAULT = 4;
  localparam int FIFO_DEPTH_DEFAULT = 4;
  typedef struct packed {
    logic [ID_BW_DEFAULT-1:0] tag;
    logic [DATA_BW_DEFAULT-1:0] data;
  } gin_pkt_t;
  function automatic int ptr_bits(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/gin_fifo_mem.sv
// gin_fifo_mem: unreset register array, one write port, asynchronous read port
module gin_fifo_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 12
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge i_clk)
    if (i_we) mem[i_waddr] <= i_wdata;
  assign o_rdata = mem[i_raddr];
endmodule

// File: rtl/gin_tag_sender.sv
// gin_tag_sender: FWFT {tag,data} queue feeding the GIN multicast bus.
// Define GIN_PKT_CNT_EN to add the saturating o_pkt_cnt bus-handshake counter.
module gin_tag_sender
  import eyeriss_pkg::*;
#(
  parameter int DATA_BITWIDTH = DATA_BW_DEFAULT,
  parameter int ID_BITWIDTH = ID_BW_DEFAULT,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [DATA_BITWIDTH-1:0]     i_data,
  input  logic [ID_BITWIDTH-1:0]       i_tag,
  input  logic                         i_valid,
  output logic                         o_ready,
  output logic [DATA_BITWIDTH-1:0]     o_data,
  output logic [ID_BITWIDTH-1:0]       o_tag,
  output logic                         o_valid,
  input  logic                         i_ready,
  input  logic                         i_flush,
  output logic [$clog2(FIFO_DEPTH):0]  o_count,
  output logic                         o_empty,
`ifdef GIN_PKT_CNT_EN
  output logic [15:0]                  o_pkt_cnt,
`endif
  output logic                         o_full
);
  localparam int PW = ptr_bits(FIFO_DEPTH);
  localparam int AW = PW - 1;
  localparam int W = ID_BITWIDTH + DATA_BITWIDTH;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [W-1:0] head;
  logic full, empty, push, pop;
  assign full = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign empty = wr_ptr == rd_ptr;
  assign push = i_valid && !full;
  assign pop = !empty && i_ready;
  assign o_ready = !full;
  assign o_valid = !empty;
  assign o_full = full;
  assign o_empty = empty;
  assign o_count = wr_ptr - rd_ptr;
  assign {o_tag, o_data} = o_valid ? head : '0;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  gin_fifo_mem #(.DEPTH(FIFO_DEPTH), .WIDTH(W)) u_mem (
    .i_clk  (i_clk),
    .i_we   (push && !i_flush),
    .i_waddr(wr_ptr[AW-1:0]),
    .i_wdata({i_tag, i_data}),
    .i_raddr(rd_ptr[AW-1:0]),
    .o_rdata(head)
  );
`ifdef GIN_PKT_CNT_EN
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) o_pkt_cnt <= '0;
    else if (i_flush) o_pkt_cnt <= '0;
    else if (pop && o_pkt_cnt != 16'hFFFF) o_pkt_cnt <= o_pkt_cnt + 16'd1;
`endif
endmodule

// File: tb/tb_gin_tag_sender.sv
// tb_gin_tag_sender: directed test-plan checks plus randomized traffic against a queue model
module tb_gin_tag_sender;
  localparam int D = 4;
  logic clk = 0, rst_n = 0;
  logic [7:0] i_data = 0;
  logic [3:0] i_tag = 0;
  logic i_valid = 0, i_ready = 0, i_flush = 0;
  logic o_ready, o_valid, o_empty, o_full;
  logic [7:0] o_data;
  logic [3:0] o_tag;
  logic [2:0] o_count;
`ifdef GIN_PKT_CNT_EN
  logic [15:0] o_pkt_cnt;
`endif
  int checks = 0, failures = 0;

  gin_tag_sender dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(i_data), .i_tag(i_tag), .i_valid(i_valid),
    .o_ready(o_ready), .o_data(o_data), .o_tag(o_tag), .o_valid(o_valid),
    .i_ready(i_ready), .i_flush(i_flush), .o_count(o_count), .o_empty(o_empty),
`ifdef GIN_PKT_CNT_EN
    .o_pkt_cnt(o_pkt_cnt),
`endif
    .o_full(o_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", n, a, e, $time);
    end
  endtask

  // Reference: an ordered packet queue plus a handshake tally
  logic [11:0] q[$];
  int hs = 0;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      q.delete();
      hs = 0;
    end else begin
      automatic bit push_ok = i_valid && q.size() < D;
      automatic bit pop_ok = i_ready && q.size() > 0;
      if (i_flush) begin
        q.delete();
        hs = 0;
      end else begin
        if (pop_ok) begin
          void'(q.pop_front());
          if (hs < 65535) hs++;
        end
        if (push_ok) q.push_back({i_tag, i_data});
      end
    end

  always @(negedge clk) begin
    automatic logic [11:0] h = q.size() > 0 ? q[0] : 12'h0;
    chk("m_valid", o_valid, q.size() > 0);
    chk("m_head", {o_tag, o_data}, h);
    chk("m_count", o_count, q.size());
    chk("m_ready", o_ready, q.size() < D);
    chk("m_empty", o_empty, q.size() == 0);
    chk("m_full", o_full, q.size() == D);
`ifdef GIN_PKT_CNT_EN
    chk("m_pkt_cnt", o_pkt_cnt, hs);
`endif
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] t, input logic [7:0] d);
    i_valid = 1; i_tag = t; i_data = d;
    cyc();
    i_valid = 0;
  endtask

  initial begin
    #2;
    chk("rst_valid", o_valid, 0);
    chk("rst_ready", o_ready, 1);
    chk("rst_empty", o_empty, 1);
    chk("rst_full", o_full, 0);
    chk("rst_head", {o_tag, o_data}, 0);
    chk("rst_count", o_count, 0);
    cyc(2);
    rst_n = 1;
    cyc();
    // single packet, then pop
    push(4'd3, 8'hA5);
    chk("single_valid", o_valid, 1);
    chk("single_tag", o_tag, 3);
    chk("single_data", o_data, 8'hA5);
    chk("single_count", o_count, 1);
    cyc(2);
    chk("single_hold", o_data, 8'hA5);
    i_ready = 1;
    cyc();
    i_ready = 0;
    chk("single_pop_valid", o_valid, 0);
    chk("single_pop_data", o_data, 0);
    chk("single_pop_empty", o_empty, 1);
    // fill, reject fifth, drain in order
    for (int i = 0; i < 4; i++) push(4'(i), 8'(10 + i));
    chk("fill_full", o_full, 1);
    chk("fill_ready", o_ready, 0);
    push(4'd4, 8'd14);
    chk("fill_reject_count", o_count, 4);
    i_ready = 1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_data", o_data, 10 + i);
      chk("drain_tag", o_tag, i);
      cyc();
    end
    chk("drain_empty", o_empty, 1);
    i_ready = 0;
    // steady push+pop at count 2
    push(4'd1, 8'd20);
    push(4'd2, 8'd21);
    i_valid = 1; i_ready = 1;
    for (int k = 0; k < 10; k++) begin
      i_data = 8'(22 + k); i_tag = 4'(k);
      chk("pp_data", o_data, 20 + k);
      cyc();
      chk("pp_count", o_count, 2);
    end
    i_valid = 0;
    cyc(2);
    i_ready = 0;
    chk("pp_drained", o_empty, 1);
    // full with simultaneous pop: push rejected, then accepted
    for (int i = 0; i < 4; i++) push(4'd7, 8'(40 + i));
    i_valid = 1; i_data = 8'd44; i_ready = 1;
    chk("fullpp_ready", o_ready, 0);
    cyc();
    chk("fullpp_count", o_count, 3);
    chk("fullpp_head", o_data, 41);
    chk("fullpp_ready_next", o_ready, 1);
    cyc();
    i_valid = 0;
    chk("fullpp_count2", o_count, 3);
    for (int i = 0; i < 3; i++) begin
      chk("fullpp_drain", o_data, 42 + i);
      cyc();
    end
    i_ready = 0;
    // flush with concurrent push
    for (int i = 0; i < 3; i++) push(4'd9, 8'(50 + i));
    i_flush = 1; i_valid = 1; i_data = 8'd53;
    cyc();
    i_flush = 0; i_valid = 0;
    chk("flush_count", o_count, 0);
    chk("flush_valid", o_valid, 0);
    cyc(2);
    chk("flush_nodrop", o_valid, 0);
    // async reset mid-cycle
    push(4'd1, 8'h61);
    push(4'd2, 8'h62);
    @(posedge clk);
    #3 rst_n = 0;
    #1;
    chk("arst_valid", o_valid, 0);
    chk("arst_count", o_count, 0);
    chk("arst_ready", o_ready, 1);
    chk("arst_head", {o_tag, o_data}, 0);
    cyc();
    rst_n = 1;
    push(4'd5, 8'h77);
    chk("arst_new_head", {o_tag, o_data}, 12'h577);
`ifdef GIN_PKT_CNT_EN
    chk("pc_start", o_pkt_cnt, 0);
    i_ready = 1; i_valid = 1;
    for (int i = 0; i < 4; i++) begin
      i_data = 8'(i);
      cyc();
    end
    i_valid = 0;
    cyc();
    i_ready = 0;
    chk("pc_five", o_pkt_cnt, 5);
    i_flush = 1;
    cyc();
    i_flush = 0;
    chk("pc_flush", o_pkt_cnt, 0);
`else
    i_ready = 1;
    cyc();
    i_ready = 0;
`endif
    // randomized traffic; the negedge process compares every cycle
    for (int c = 0; c < 3000; c++) begin
      i_valid = $urandom_range(0, 99) < 60;
      i_ready = $urandom_range(0, 99) < 45;
      i_flush = $urandom_range(0, 99) < 2;
      i_data = 8'($urandom);
      i_tag = 4'($urandom);
      cyc();
    end
    i_valid = 0; i_flush = 0; i_ready = 0;
    cyc(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
